// File: rtl/convert_fixed_to_float_if.sv
// Handshake and data bundle for the fixed-to-float converter.
//   Begin_FSM_FF : start request (master -> slave)
//   Fixed        : W-bit two's-complement input word (master -> slave)
//   Float        : IEEE-754 single-precision result (slave -> master)
//   ACK_FF       : conversion complete, high throughout DONE (slave -> master)
interface convert_fixed_to_float_if #(
  parameter int unsigned W = 32
);
  logic         Begin_FSM_FF;
  logic [W-1:0] Fixed;
  logic [31:0]  Float;
  logic         ACK_FF;

  modport master (
    output Begin_FSM_FF,
    output Fixed,
    input  Float,
    input  ACK_FF
  );

  modport slave (
    input  Begin_FSM_FF,
    input  Fixed,
    output Float,
    output ACK_FF
  );
endinterface

// File: rtl/convert_fixed_to_float.sv
// Multi-cycle signed fixed-point to IEEE-754 single-precision converter.
// Normalizes the magnitude by one left shift per cycle, then packs sign,
// biased exponent and truncated mantissa into the Float register.
//   CLK    : system clock, rising edge
//   RST_FF : asynchronous active-high reset
//   bus    : slave side of convert_fixed_to_float_if (Begin/Fixed in,
//            Float/ACK out)
module convert_fixed_to_float #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 26
) (
  input  logic                     CLK,
  input  logic                     RST_FF,
  convert_fixed_to_float_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(W);
  // Exponent of a value whose leading one sits at mag_r[W-1] with no shifts.
  localparam int unsigned EXP_BIAS = 127 + W - 1 - FRAC;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] PACK = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state,   state_nxt;
  logic             sign_r,  sign_nxt;
  logic [W-1:0]     mag_r,   mag_nxt;
  logic [CNT_W-1:0] cnt,     cnt_nxt;
  logic [31:0]      float_r, float_nxt;
  logic             ack_r;
  logic [7:0]       exp_c;

  // Parameter limits keep the exponent in 1..254, so 8-bit wraparound
  // arithmetic yields the same bits as the full 9-bit difference.
  assign exp_c = 8'(EXP_BIAS) - 8'(cnt);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    sign_nxt  = sign_r;
    mag_nxt   = mag_r;
    cnt_nxt   = cnt;
    float_nxt = float_r;
    case (state)
      IDLE: begin
        if (bus.Begin_FSM_FF) begin
          sign_nxt  = bus.Fixed[W-1];
          // W-bit negate: the most negative input maps to 2^(W-1) cleanly.
          mag_nxt   = bus.Fixed[W-1] ? W'(~bus.Fixed + W'(1)) : bus.Fixed;
          cnt_nxt   = '0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if ((mag_r == '0) || mag_r[W-1]) begin
          state_nxt = PACK;
        end else begin
          mag_nxt = {mag_r[W-2:0], 1'b0};
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PACK: begin
        // Zero forces +0; otherwise drop the hidden bit and truncate.
        if (mag_r == '0) begin
          float_nxt = 32'h0000_0000;
        end else begin
          float_nxt = {sign_r, exp_c, mag_r[W-2:W-24]};
        end
        state_nxt = DONE;
      end
      DONE: begin
        if (!bus.Begin_FSM_FF) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; ACK tracks entry into DONE.
  always_ff @(posedge CLK or posedge RST_FF) begin
    if (RST_FF) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      mag_r   <= '0;
      cnt     <= '0;
      float_r <= 32'h0000_0000;
      ack_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      sign_r  <= sign_nxt;
      mag_r   <= mag_nxt;
      cnt     <= cnt_nxt;
      float_r <= float_nxt;
      ack_r   <= (state_nxt == DONE);
    end
  end

  assign bus.Float  = float_r;
  assign bus.ACK_FF = ack_r;

endmodule

// File: tb/tb_convert_fixed_to_float.sv
// Self-checking bench for convert_fixed_to_float: directed vector table,
// handshake/reset sequences, and randomized conversions against a model.
module tb_convert_fixed_to_float;

  localparam int unsigned W    = 32;
  localparam int unsigned FRAC = 26;
  localparam int          MAX_EDGES = 60;

  logic CLK;
  logic RST_FF;
  int   checks;
  int   errors;

  convert_fixed_to_float_if #(.W(W)) bus ();

  convert_fixed_to_float #(.W(W), .FRAC(FRAC)) dut (
    .CLK    (CLK),
    .RST_FF (RST_FF),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] fixed;
    logic [31:0]  exp_float;
    int           exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: value = signed(f) / 2^FRAC, expressed as sign * 1.m * 2^e with
  // the mantissa truncated; latency = leading zeros + 2 (2 for zero).
  function automatic void model(input logic [W-1:0] f, output logic [31:0] fl,
                                output int lat);
    logic            s;
    longint unsigned m;
    longint unsigned frac_part;
    int              p;
    int              e;
    s = f[W-1];
    m = s ? ((64'd1 << W) - 64'(f)) : 64'(f);
    if (m == 0) begin
      fl  = 32'h0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (m >= (64'd1 << i)) p = i;
    e = 127 + p - int'(FRAC);
    frac_part = m - (64'd1 << p);
    if (p >= 23) frac_part = frac_part >> (p - 23);
    else         frac_part = frac_part << (23 - p);
    fl  = {s, 8'(e), 23'(frac_part)};
    lat = int'(W) - 1 - p + 2;
  endfunction

  // Start a conversion and wait for ACK; edge 0 samples Begin.
  task automatic run(input logic [W-1:0] f, input bit hold, input bit toggle,
                     output logic [31:0] fl, output int lat);
    bit ok;
    int edges;
    @(negedge CLK);
    bus.Fixed        = f;
    bus.Begin_FSM_FF = 1'b1;
    @(posedge CLK);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < MAX_EDGES && !ok; i++) begin
      @(posedge CLK);
      edges++;
      #1;
      if (bus.ACK_FF) ok = 1'b1;
      else if (toggle) begin
        bus.Begin_FSM_FF = 1'($urandom);
        bus.Fixed        = W'($urandom);
      end else if (!hold) bus.Begin_FSM_FF = 1'b0;
    end
    chk("ack_timeout", 32'(ok), 32'd1);
    fl  = bus.Float;
    lat = edges;
  endtask

  // Drop Begin in DONE; ACK must fall at the next edge and Float must hold.
  task automatic release_done(input logic [31:0] fl);
    bus.Begin_FSM_FF = 1'b0;
    @(posedge CLK);
    #1;
    chk("ack_after_drop", 32'(bus.ACK_FF), 32'd0);
    chk("float_hold_idle", bus.Float, fl);
  endtask

  task automatic convert_and_check(input string name, input logic [W-1:0] f,
                                   input bit toggle);
    logic [31:0] fl, efl;
    int          lat, elat;
    model(f, efl, elat);
    run(f, 1'b0, toggle, fl, lat);
    chk({name, "_float"}, fl, efl);
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    release_done(fl);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] fl;
    int          lat;
    logic [W-1:0] rf;

    checks = 0;
    errors = 0;
    vecs[0] = '{32'h0400_0000, 32'h3F80_0000, 7};
    vecs[1] = '{32'hFA00_0000, 32'hBFC0_0000, 7};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 2};
    vecs[3] = '{32'h8000_0000, 32'hC200_0000, 2};
    vecs[4] = '{32'h0000_0001, 32'h3280_0000, 33};
    vecs[5] = '{32'h7FFF_FFFF, 32'h41FF_FFFF, 3};

    RST_FF           = 1'b1;
    bus.Begin_FSM_FF = 1'b0;
    bus.Fixed        = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ack", 32'(bus.ACK_FF), 32'd0);
    chk("reset_float", bus.Float, 32'h0);
    @(negedge CLK);
    RST_FF = 1'b0;

    // Directed vectors with fixed expectations.
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].fixed, 1'b0, 1'b0, fl, lat);
      chk($sformatf("vec%0d_float", i), fl, vecs[i].exp_float);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      release_done(fl);
    end

    // Begin held high after ACK: stay in DONE with stable output.
    run(32'hFA00_0000, 1'b1, 1'b0, fl, lat);
    chk("hold_float", fl, 32'hBFC0_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_ack", 32'(bus.ACK_FF), 32'd1);
      chk("hold_float_stable", bus.Float, 32'hBFC0_0000);
    end
    release_done(32'hBFC0_0000);

    // Inputs toggled during NORM must not disturb the result.
    convert_and_check("toggle", 32'h0400_0000, 1'b1);

    // Reset during NORM of a long conversion.
    @(negedge CLK);
    bus.Fixed        = 32'h0000_0001;
    bus.Begin_FSM_FF = 1'b1;
    @(posedge CLK);
    #1;
    bus.Begin_FSM_FF = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST_FF = 1'b1;
    #1;
    chk("midreset_ack", 32'(bus.ACK_FF), 32'd0);
    chk("midreset_float", bus.Float, 32'h0);
    @(negedge CLK);
    RST_FF = 1'b0;
    run(32'h0400_0000, 1'b0, 1'b0, fl, lat);
    chk("postreset_float", fl, 32'h3F80_0000);
    chk("postreset_latency", 32'(lat), 32'd7);
    release_done(fl);

    // Randomized magnitudes across the full leading-zero range.
    for (int i = 0; i < 40; i++) begin
      rf = W'($urandom) >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rf = W'(-rf);
      convert_and_check($sformatf("rand%0d", i), rf, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
